// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq
// Shares one small add/sub/and/or ALU between two requesters. A round-robin
// arbiter accepts one operation at a time and registers its operands. The
// result is computed one cycle later. It is then held on a single shared
// response channel until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   reqN_valid/reqN_ready requester N handshake (N = 0, 1)
//   reqN_a, reqN_b        4-bit operands of requester N
//   reqN_op               0 add, 1 sub, 2 and, 3 or
//   rsp_valid/rsp_ready   response handshake with backpressure
//   rsp_data              8-bit result (operands zero-extended)
//   rsp_id                requester that issued the result
//   op_count              completed responses, wraps modulo 2^CNT_W
module alu_arbiter_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic [3:0] lat_a;
  logic [3:0] lat_b;
  logic [1:0] lat_op;
  logic       lat_id;
  logic       grant_id;
  logic       accept;
  logic [7:0] alu_result;

  // Arbitration. On a tie the grant goes to the requester that did not win
  // last time. The ready outputs are gated with rst_n so that they stay low
  // while reset is held, even though the state register already reads IDLE.
  always_comb begin
    grant_id   = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. EXEC always lasts exactly one cycle. RESP waits for
  // the consumer. Returning to IDLE only after the handshake means an accept
  // can never fall in the same cycle as the response handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU on the latched operands. Both operands are zero-extended to 8 bits,
  // so a subtraction that goes negative wraps modulo 256.
  always_comb begin
    alu_result = 8'h00;
    case (lat_op)
      2'd0:    alu_result = {4'h0, lat_a} + {4'h0, lat_b};
      2'd1:    alu_result = {4'h0, lat_a} - {4'h0, lat_b};
      2'd2:    alu_result = {4'h0, lat_a & lat_b};
      default: alu_result = {4'h0, lat_a | lat_b};
    endcase
  end

  // Datapath registers: operand capture on accept, result capture in EXEC,
  // and the response handshake in RESP. rsp_data and rsp_id keep their
  // value after the handshake. Only rsp_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_a      <= 4'h0;
      lat_b      <= 4'h0;
      lat_op     <= 2'd0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        lat_a      <= grant_id ? req1_a  : req0_a;
        lat_b      <= grant_id ? req1_b  : req0_b;
        lat_op     <= grant_id ? req1_op : req0_op;
        lat_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_result;
        rsp_id    <= lat_id;
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq
// Drives directed operations into two instances of alu_arbiter_seq. Both
// instances receive identical inputs. One instance uses the default counter
// width and the other uses CNT_W=2 to exercise counter wrap. Expected results
// are pushed into a queue when an operation is accepted. An independent
// monitor pops the queue on every response handshake and compares.
module tb_alu_arbiter_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp_ready;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0] rsp_data;
  logic [7:0] op_count;

  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
  logic [7:0] s_rsp_data;
  logic [1:0] s_op_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int accept_cycle;
  int hs_cycle;
  logic ready_at_hs;
  logic [8:0] exp_q[$];

  // Per-requester operand tables for the contention run
  logic [3:0] r0_a [2] = '{4'd1, 4'd15};
  logic [3:0] r0_b [2] = '{4'd2, 4'd15};
  logic [1:0] r0_o [2] = '{2'd0, 2'd0};
  logic [7:0] r0_e [2] = '{8'h03, 8'h1E};
  logic [3:0] r1_a [2] = '{4'd4, 4'd12};
  logic [3:0] r1_b [2] = '{4'd6, 4'd10};
  logic [1:0] r1_o [2] = '{2'd1, 2'd3};
  logic [7:0] r1_e [2] = '{8'hFE, 8'h0E};

  alu_arbiter_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .op_count(op_count)
  );

  alu_arbiter_seq #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(s_rsp_data), .rsp_id(s_rsp_id), .op_count(s_op_count)
  );

  // 10 ns clock and a posedge counter for the cycle-accurate checks
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  // Raises valid for one requester and waits for its ready. When push_exp
  // is set, the expected response is queued at accept time. Valid is
  // dropped just after the accepting edge.
  task automatic applyStimulus(input logic id, input logic [3:0] a,
                               input logic [3:0] b, input logic [1:0] op,
                               input logic [7:0] exp, input logic push_exp);
    logic got;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    checkOutput("accept", 32'(got), 32'd1);
    if (got) begin
      checkOutput("other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
      accept_cycle = cycle;
      if (push_exp) exp_q.push_back({id, exp});
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Bounded wait for a response handshake. Returns just after its edge.
  task automatic waitResponse();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = rsp_valid && rsp_ready;
    end
    checkOutput("rsp_timeout", 32'(done), 32'd1);
    hs_cycle    = cycle;
    ready_at_hs = req0_ready | req1_ready;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected: got id=%0d data=%0h, expected none",
                 rsp_id, rsp_data);
      end else begin
        exp = exp_q.pop_front();
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp[7:0]));
        checkOutput("rsp_id", 32'(rsp_id), 32'(exp[8]));
        checkOutput("small_rsp_data", 32'(s_rsp_data), 32'(exp[7:0]));
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic got;
    int   i0, i1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0; req0_op = 2'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 2'd0;
    rsp_ready  = 1'b1;

    // Reset state, with a requester already valid
    #3;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add with latency check
    $display("[TB] single add");
    applyStimulus(1'b0, 4'd9, 4'd7, 2'd0, 8'h10, 1'b1);
    @(negedge clk);
    checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("exec_req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk);
    checkOutput("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    checkOutput("op_count_1", 32'(op_count), 32'd1);
    checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_hs_data_kept", 32'(rsp_data), 32'h10);

    // All ops on requester 1, plus a zero subtraction
    $display("[TB] requester 1 ops");
    applyStimulus(1'b1, 4'd3, 4'd5, 2'd1, 8'hFE, 1'b1); waitResponse();
    applyStimulus(1'b1, 4'd3, 4'd5, 2'd2, 8'h01, 1'b1); waitResponse();
    applyStimulus(1'b1, 4'd3, 4'd5, 2'd3, 8'h07, 1'b1); waitResponse();
    applyStimulus(1'b1, 4'd0, 4'd0, 2'd1, 8'h00, 1'b1); waitResponse();
    checkOutput("op_count_5", 32'(op_count), 32'd5);
    checkOutput("small_op_count_wrap", 32'(s_op_count), 32'd1);

    // Backpressure: hold the response for 5 cycles while requester 1 waits
    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    req1_a = 4'd10; req1_b = 4'd5; req1_op = 2'd2; req1_valid = 1'b1;
    applyStimulus(1'b0, 4'd6, 4'd3, 2'd1, 8'h03, 1'b1);
    req1_valid = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data", 32'(rsp_data), 32'h03);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_ready0", 32'(req0_ready), 32'd0);
      checkOutput("bp_ready1", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    waitResponse();
    checkOutput("bp_no_accept_at_hs", 32'(ready_at_hs), 32'd0);
    applyStimulus(1'b1, 4'd10, 4'd5, 2'd2, 8'h00, 1'b1);
    checkOutput("bp_accept_cycle", 32'(accept_cycle), 32'(hs_cycle + 1));
    waitResponse();
    checkOutput("op_count_7", 32'(op_count), 32'd7);

    // Reset in RESP discards the in-flight result
    $display("[TB] reset mid-operation");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'd2, 4'd2, 2'd0, 8'h04, 1'b0);
    @(negedge clk); @(negedge clk);
    checkOutput("pre_reset_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(rsp_data), 32'd0);
    checkOutput("mid_rst_op_count", 32'(op_count), 32'd0);
    checkOutput("mid_rst_small_count", 32'(s_op_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 4'd7, 4'd8, 2'd0, 8'h0F, 1'b1);
    waitResponse();
    checkOutput("after_rst_op_count", 32'(op_count), 32'd1);

    // Contention: both requesters valid continuously. Operands of a granted
    // requester change while its operation is in flight.
    $display("[TB] contention");
    i0 = 0; i1 = 0;
    req0_a = r0_a[0]; req0_b = r0_b[0]; req0_op = r0_o[0];
    req1_a = r1_a[0]; req1_b = r1_b[0]; req1_op = r1_o[0];
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = req0_ready | req1_ready;
      end
      checkOutput("cont_accept", 32'(got), 32'd1);
      checkOutput("cont_grant_id", 32'(req1_ready), 32'(k % 2));
      checkOutput("cont_one_hot", 32'(req0_ready & req1_ready), 32'd0);
      if (req1_ready) begin
        exp_q.push_back({1'b1, r1_e[i1]});
        i1++;
      end else if (req0_ready) begin
        exp_q.push_back({1'b0, r0_e[i0]});
        i0++;
      end
      @(posedge clk); #1;
      if (i0 < 2) begin req0_a = r0_a[i0]; req0_b = r0_b[i0]; req0_op = r0_o[i0]; end
      if (i1 < 2) begin req1_a = r1_a[i1]; req1_b = r1_b[i1]; req1_op = r1_o[i1]; end
      @(negedge clk);
      checkOutput("cont_ready_pulse", 32'(req0_ready | req1_ready), 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    checkOutput("final_op_count", 32'(op_count), 32'd5);
    checkOutput("final_small_op_count", 32'(s_op_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
